// File: rtl/game_pkg.sv
// game_pkg -- shared definitions for the game flow controller.
//   game_state_e : encoded game state (IDLE/PLAY/PAUSE/HIT/OVER)
//   DEF_*        : default values for the controller parameters
//   sat_inc16    : saturating 16-bit increment used by the frame counter
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_PAUSE = 3'd2,
    ST_HIT   = 3'd3,
    ST_OVER  = 3'd4
  } game_state_e;

  localparam int unsigned DEF_LIVES      = 3;
  localparam int unsigned DEF_HIT_FRAMES = 60;
  localparam int unsigned DEF_V_ACTIVE   = 480;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] res;
    if (v == 16'hFFFF) begin
      res = v;
    end else begin
      res = v + 16'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// edge_detect -- registers a level input and flags its rising edge.
//   clk     : clock
//   rst     : synchronous active-high reset
//   i_level : raw level (button)
//   o_rise  : high for one cycle, the cycle after the level is first seen high
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_rise
);

  logic r_level;
  logic r_level_d;

  // Sample the level and keep its previous registered value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
    end else begin
      r_level   <= i_level;
      r_level_d <= r_level;
    end
  end

  // Both operands are registers, so the edge flag is glitch-free.
  assign o_rise = r_level & ~r_level_d;

endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl -- top-level game state machine.
//   clk, rst           : pixel clock, synchronous active-high reset
//   pxl_x, pxl_y       : current pixel position (frame tick source)
//   start_btn          : Start button level
//   select_btn         : Select button level
//   collision          : player/enemy overlap at the current pixel
//   frame_tick         : one-cycle pulse per frame
//   game_state         : encoded state (see game_pkg)
//   obj_enable         : per-frame move strobe for object units
//   obj_resetN         : active-low reset for object units
//   lives              : remaining lives
//   play_frames        : frames spent in PLAY this game (saturating)
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int unsigned LIVES      = DEF_LIVES,
  parameter int unsigned HIT_FRAMES = DEF_HIT_FRAMES,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pxl_x,
  input  logic [31:0] pxl_y,
  input  logic        start_btn,
  input  logic        select_btn,
  input  logic        collision,
  output logic        frame_tick,
  output logic [2:0]  game_state,
  output logic        obj_enable,
  output logic        obj_resetN,
  output logic [2:0]  lives,
  output logic [15:0] play_frames
);

  localparam logic [2:0]  LIVES_L      = 3'(LIVES);
  localparam logic [7:0]  HIT_FRAMES_L = 8'(HIT_FRAMES);
  localparam logic [31:0] V_ACTIVE_L   = 32'(V_ACTIVE);

  logic        w_at_vblank;
  logic        w_tick;
  logic        w_start_ev;
  logic        w_select_ev;
  logic        w_hit;
  logic        w_respawn;

  logic        r_at_vblank;
  logic        r_frame_tick;
  game_state_e r_state;
  game_state_e w_state_nxt;
  logic        r_obj_enable;
  logic        w_obj_enable_nxt;
  logic        r_obj_resetN;
  logic        w_obj_resetN_nxt;
  logic [2:0]  r_lives;
  logic [2:0]  w_lives_nxt;
  logic [15:0] r_play_frames;
  logic [15:0] w_play_frames_nxt;
  logic        r_hit_latch;
  logic        w_hit_latch_nxt;
  logic [7:0]  r_hit_cnt;
  logic [7:0]  w_hit_cnt_nxt;

  edge_detect u_start_ed (
    .clk     (clk),
    .rst     (rst),
    .i_level (start_btn),
    .o_rise  (w_start_ev)
  );

  edge_detect u_select_ed (
    .clk     (clk),
    .rst     (rst),
    .i_level (select_btn),
    .o_rise  (w_select_ev)
  );

  // The FSM acts on w_tick in the same cycle that r_frame_tick is loaded,
  // so obj_enable and every state/counter change line up with frame_tick.
  assign w_at_vblank = (pxl_x == 32'd0) && (pxl_y == V_ACTIVE_L);
  assign w_tick      = w_at_vblank & ~r_at_vblank;
  // A collision arriving with the tick still belongs to the ending frame.
  assign w_hit       = w_tick & (r_hit_latch | collision);

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt       = r_state;
    w_lives_nxt       = r_lives;
    w_play_frames_nxt = r_play_frames;
    w_hit_latch_nxt   = 1'b0;
    w_hit_cnt_nxt     = r_hit_cnt;
    w_obj_enable_nxt  = 1'b0;
    w_respawn         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_lives_nxt = 3'd0;
        if (w_start_ev) begin
          w_state_nxt       = ST_PLAY;
          w_lives_nxt       = LIVES_L;
          w_play_frames_nxt = 16'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_PLAY: begin
        w_obj_enable_nxt = w_tick;
        if (w_tick) begin
          w_play_frames_nxt = sat_inc16(r_play_frames);
          w_hit_latch_nxt   = 1'b0;
        end else begin
          w_hit_latch_nxt = r_hit_latch | collision;
        end
        // A hit outranks any button event of the same cycle.
        if (w_hit) begin
          w_lives_nxt = r_lives - 3'd1;
          if (r_lives == 3'd1) begin
            w_state_nxt = ST_OVER;
          end else begin
            w_state_nxt   = ST_HIT;
            w_hit_cnt_nxt = HIT_FRAMES_L;
          end
        end else if (w_start_ev) begin
          w_state_nxt = ST_IDLE;
          w_lives_nxt = 3'd0;
        end else if (w_select_ev) begin
          w_state_nxt = ST_PAUSE;
        end else begin
          w_state_nxt = ST_PLAY;
        end
      end

      ST_PAUSE: begin
        if (w_start_ev) begin
          w_state_nxt = ST_IDLE;
          w_lives_nxt = 3'd0;
        end else if (w_select_ev) begin
          w_state_nxt = ST_PLAY;
        end else begin
          w_state_nxt = ST_PAUSE;
        end
      end

      ST_HIT: begin
        if (w_tick) begin
          // Counter value 1 becomes 0 on this tick: respawn now.
          if (r_hit_cnt <= 8'd1) begin
            w_state_nxt   = ST_PLAY;
            w_hit_cnt_nxt = 8'd0;
            w_respawn     = 1'b1;
          end else begin
            w_hit_cnt_nxt = r_hit_cnt - 8'd1;
          end
        end else begin
          w_hit_cnt_nxt = r_hit_cnt;
        end
      end

      ST_OVER: begin
        if (w_start_ev) begin
          w_state_nxt = ST_IDLE;
          w_lives_nxt = 3'd0;
        end else begin
          w_state_nxt = ST_OVER;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_lives_nxt = 3'd0;
      end
    endcase

    // Object units are held in reset while idle and for the respawn cycle.
    w_obj_resetN_nxt = (w_state_nxt != ST_IDLE) && !w_respawn;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_at_vblank   <= 1'b0;
      r_frame_tick  <= 1'b0;
      r_state       <= ST_IDLE;
      r_obj_enable  <= 1'b0;
      r_obj_resetN  <= 1'b0;
      r_lives       <= 3'd0;
      r_play_frames <= 16'd0;
      r_hit_latch   <= 1'b0;
      r_hit_cnt     <= 8'd0;
    end else begin
      r_at_vblank   <= w_at_vblank;
      r_frame_tick  <= w_tick;
      r_state       <= w_state_nxt;
      r_obj_enable  <= w_obj_enable_nxt;
      r_obj_resetN  <= w_obj_resetN_nxt;
      r_lives       <= w_lives_nxt;
      r_play_frames <= w_play_frames_nxt;
      r_hit_latch   <= w_hit_latch_nxt;
      r_hit_cnt     <= w_hit_cnt_nxt;
    end
  end

  assign frame_tick  = r_frame_tick;
  assign game_state  = r_state;
  assign obj_enable  = r_obj_enable;
  assign obj_resetN  = r_obj_resetN;
  assign lives       = r_lives;
  assign play_frames = r_play_frames;

endmodule
